memory_responder: RTL and testbench

Memory-side responder for the pipelined datapath's two memory ports. It services the instruction port (i_address/i_data) and the data port (d_address/d_data) from one shared word array. Each port has its own fixed-latency request/ready handshake. It sits opposite the datapath in the top level, owns both bidirectional data buses whenever it returns read data, and produces the completion pulse the datapath consumes as input_ready.

---
 rtl/memory_responder_pkg.sv | 17 +
 rtl/memory_responder_mem_port_fsm.sv | 105 ++++++++++
 rtl/memory_responder.sv | 81 ++++++++
 tb/tb_memory_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared FSM encodings and counter helpers for the memory responder and its
// per-port access sequencer.
package memory_responder_pkg;

  typedef enum logic [1:0] {
    MEMST_IDLE = 2'd0,
    MEMST_BUSY = 2'd1,
    MEMST_DONE = 2'd2
  } memst_e;

  localparam int CNT_WIDTH = 4;

  function automatic logic [CNT_WIDTH-1:0] latency_load(input int latency);
    return CNT_WIDTH'(latency - 1);
  endfunction

endpackage

// File: rtl/memory_responder_mem_port_fsm.sv
// One memory port's access sequencer: accepts a request, counts out the fixed
// latency, then strobes the array access and raises ready for one cycle.
module mem_port_fsm
  import memory_responder_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_index,
  input  logic [WORD_SIZE-1:0]  i_wdata,
  output logic                  o_commit,
  output logic                  o_commit_write,
  output logic [ADDR_WIDTH-1:0] o_index,
  output logic [WORD_SIZE-1:0]  o_wdata,
  output logic                  o_ready,
  output logic                  o_drive
);

  localparam logic [CNT_WIDTH-1:0] LOAD = latency_load(LATENCY);

  memst_e                r_state;
  memst_e                w_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [ADDR_WIDTH-1:0] r_index;
  logic                  r_write;
  logic [WORD_SIZE-1:0]  r_wdata;
  logic                  r_ready;
  logic                  r_drive;
  logic                  w_idle;
  logic                  w_accept;

  assign w_idle   = (r_state == MEMST_IDLE);
  assign w_accept = w_idle && (i_read || i_write);

  // With LATENCY==1 the access commits on the accepting edge, so the live
  // request fields are used in IDLE; otherwise the latched copies.
  assign o_commit_write = w_idle ? i_write : r_write;
  assign o_index        = w_idle ? i_index : r_index;
  assign o_wdata        = w_idle ? i_wdata : r_wdata;
  assign o_ready        = r_ready;
  assign o_drive        = r_drive;

  // Next-state decode and commit strobe
  always_comb begin
    w_next   = r_state;
    o_commit = 1'b0;
    case (r_state)
      MEMST_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_next   = MEMST_DONE;
            o_commit = 1'b1;
          end else begin
            w_next = MEMST_BUSY;
          end
        end else begin
          w_next = MEMST_IDLE;
        end
      end
      MEMST_BUSY: begin
        if (r_cnt == {CNT_WIDTH{1'b0}}) begin
          w_next   = MEMST_DONE;
          o_commit = 1'b1;
        end else begin
          w_next = MEMST_BUSY;
        end
      end
      MEMST_DONE: w_next = MEMST_IDLE;
      default:    w_next = MEMST_IDLE;
    endcase
  end

  // State, latency counter, latched request and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MEMST_IDLE;
      r_cnt   <= {CNT_WIDTH{1'b0}};
      r_index <= {ADDR_WIDTH{1'b0}};
      r_write <= 1'b0;
      r_wdata <= {WORD_SIZE{1'b0}};
      r_ready <= 1'b0;
      r_drive <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == MEMST_DONE);
      r_drive <= (w_next == MEMST_DONE) && !o_commit_write;
      if (w_accept) begin
        r_cnt   <= LOAD;
        r_index <= i_index;
        r_write <= i_write;
        if (i_write) begin
          r_wdata <= i_wdata;
        end
      end else if ((r_state == MEMST_BUSY) && (r_cnt != {CNT_WIDTH{1'b0}})) begin
        r_cnt <= r_cnt - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Dual-port memory responder: one shared word array serviced by independent
// instruction and data port sequencers with tri-state read-data return.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  input  logic                 d_mem_read,
  input  logic                 d_mem_write,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 i_ready,
  output logic                 d_ready
);

  logic [WORD_SIZE-1:0]  r_mem [0:(2**ADDR_WIDTH)-1];
  logic [WORD_SIZE-1:0]  r_i_rdata;
  logic [WORD_SIZE-1:0]  r_d_rdata;
  logic                  w_i_commit, w_i_cwrite, w_i_drive, w_i_we;
  logic                  w_d_commit, w_d_cwrite, w_d_drive, w_d_we;
  logic [ADDR_WIDTH-1:0] w_i_index, w_d_index;
  logic [WORD_SIZE-1:0]  w_i_wdata, w_d_wdata;
  logic                  w_unused;

  // Upper address bits alias onto the array and are deliberately dropped.
  assign w_unused = &{1'b0, i_address[WORD_SIZE-1:ADDR_WIDTH], d_address[WORD_SIZE-1:ADDR_WIDTH]};

  mem_port_fsm #(.WORD_SIZE(WORD_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) u_i_port (
    .clk(clk), .reset(reset), .i_read(i_mem_read), .i_write(i_mem_write),
    .i_index(i_address[ADDR_WIDTH-1:0]), .i_wdata(i_data),
    .o_commit(w_i_commit), .o_commit_write(w_i_cwrite), .o_index(w_i_index),
    .o_wdata(w_i_wdata), .o_ready(i_ready), .o_drive(w_i_drive)
  );

  mem_port_fsm #(.WORD_SIZE(WORD_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) u_d_port (
    .clk(clk), .reset(reset), .i_read(d_mem_read), .i_write(d_mem_write),
    .i_index(d_address[ADDR_WIDTH-1:0]), .i_wdata(d_data),
    .o_commit(w_d_commit), .o_commit_write(w_d_cwrite), .o_index(w_d_index),
    .o_wdata(w_d_wdata), .o_ready(d_ready), .o_drive(w_d_drive)
  );

  assign w_i_we = w_i_commit && w_i_cwrite && !reset;
  assign w_d_we = w_d_commit && w_d_cwrite && !reset;

  // Array write port; the data-port write is ordered last so it wins a same-index collision
  always_ff @(posedge clk) begin
    if (w_i_we) begin
      r_mem[w_i_index] <= w_i_wdata;
    end
    if (w_d_we) begin
      r_mem[w_d_index] <= w_d_wdata;
    end
  end

  // Read-data capture; sees pre-write contents on a same-edge collision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_rdata <= {WORD_SIZE{1'b0}};
      r_d_rdata <= {WORD_SIZE{1'b0}};
    end else begin
      if (w_i_commit && !w_i_cwrite) begin
        r_i_rdata <= r_mem[w_i_index];
      end
      if (w_d_commit && !w_d_cwrite) begin
        r_d_rdata <= r_mem[w_d_index];
      end
    end
  end

  assign i_data = w_i_drive ? r_i_rdata : {WORD_SIZE{1'bz}};
  assign d_data = w_d_drive ? r_d_rdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

  localparam int LAT = 2;

  typedef struct {
    logic        is_read;
    logic [15:0] data;
    int          rdy_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_rd, i_wr, d_rd, d_wr;
  logic [15:0] i_addr, d_addr, i_val, d_val;
  wire  [15:0] i_bus, d_bus;
  logic        i_rdy, d_rdy;

  logic        u_i_rd, u_i_wr, u_d_rd, u_d_wr;
  logic [15:0] u_i_addr, u_d_addr, u_i_val, u_d_val;
  wire  [15:0] u_i_bus, u_d_bus;
  logic        u_i_rdy, u_d_rdy;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t iq[$];
  exp_t dq[$];

  // The bench drives a known value whenever the responder is not signalling ready.
  assign i_bus   = i_rdy   ? 16'hzzzz : i_val;
  assign d_bus   = d_rdy   ? 16'hzzzz : d_val;
  assign u_i_bus = u_i_rdy ? 16'hzzzz : u_i_val;
  assign u_d_bus = u_d_rdy ? 16'hzzzz : u_d_val;

  memory_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset(rst),
    .i_mem_read(i_rd), .i_mem_write(i_wr), .i_address(i_addr), .i_data(i_bus),
    .d_mem_read(d_rd), .d_mem_write(d_wr), .d_address(d_addr), .d_data(d_bus),
    .i_ready(i_rdy), .d_ready(d_rdy)
  );

  memory_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst),
    .i_mem_read(u_i_rd), .i_mem_write(u_i_wr), .i_address(u_i_addr), .i_data(u_i_bus),
    .d_mem_read(u_d_rd), .d_mem_write(u_d_wr), .d_address(u_d_addr), .d_data(u_d_bus),
    .i_ready(u_i_rdy), .d_ready(u_d_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every ready pulse pops an expectation; idle cycles must leave the bus to the bench.
  always @(negedge clk) begin
    exp_t e;
    if (d_rdy) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL d_unexpected_ready cyc=%0d got ready=1 want 0", cyc);
      end else begin
        e = dq.pop_front();
        if (cyc != e.rdy_cyc) begin
          failures++;
          $display("FAIL d_ready_cycle got cyc=%0d want cyc=%0d", cyc, e.rdy_cyc);
        end
        if (e.is_read) begin
          checks++;
          if (d_bus !== e.data) begin
            failures++;
            $display("FAIL d_read_data got %h want %h", d_bus, e.data);
          end
        end
      end
    end else begin
      checks++;
      if (d_bus !== d_val) begin
        failures++;
        $display("FAIL d_bus_released cyc=%0d got %h want %h", cyc, d_bus, d_val);
      end
    end
    if (i_rdy) begin
      checks++;
      if (iq.size() == 0) begin
        failures++;
        $display("FAIL i_unexpected_ready cyc=%0d got ready=1 want 0", cyc);
      end else begin
        e = iq.pop_front();
        if (cyc != e.rdy_cyc) begin
          failures++;
          $display("FAIL i_ready_cycle got cyc=%0d want cyc=%0d", cyc, e.rdy_cyc);
        end
        if (e.is_read) begin
          checks++;
          if (i_bus !== e.data) begin
            failures++;
            $display("FAIL i_read_data got %h want %h", i_bus, e.data);
          end
        end
      end
    end else begin
      checks++;
      if (i_bus !== i_val) begin
        failures++;
        $display("FAIL i_bus_released cyc=%0d got %h want %h", cyc, i_bus, i_val);
      end
    end
  end

  task automatic d_req(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rdata);
    exp_t e;
    d_rd = rd; d_wr = wr; d_addr = addr;
    d_val = wr ? wdata : 16'h0000;
    e.is_read = !wr; e.data = exp_rdata; e.rdy_cyc = cyc + 1 + LAT;
    dq.push_back(e);
  endtask

  task automatic i_req(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rdata);
    exp_t e;
    i_rd = rd; i_wr = wr; i_addr = addr;
    i_val = wr ? wdata : 16'h0000;
    e.is_read = !wr; e.data = exp_rdata; e.rdy_cyc = cyc + 1 + LAT;
    iq.push_back(e);
  endtask

  // Holds each outstanding request until its ready is seen, then drops it.
  task automatic finish_reqs();
    logic di, dd;
    int   n;
    n = 0;
    while ((i_rd || i_wr || d_rd || d_wr) && n < 20) begin
      @(negedge clk);
      di = i_rdy; dd = d_rdy;
      @(posedge clk); #1;
      if (di) begin i_rd = 1'b0; i_wr = 1'b0; i_val = 16'h0000; end
      if (dd) begin d_rd = 1'b0; d_wr = 1'b0; d_val = 16'h0000; end
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL ready_timeout waited %0d cycles want ready within 20", n);
      i_rd = 1'b0; i_wr = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
      i_val = 16'h0000; d_val = 16'h0000;
      iq.delete(); dq.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (i_rdy !== 1'b0 || d_rdy !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready got i=%b d=%b want 0 0", i_rdy, d_rdy);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    d_req(1'b0, 1'b1, 16'h0005, 16'hCAFE, 16'h0000);
    finish_reqs();
    // Write that will be abandoned in BUSY: no scoreboard entry, so any ready is flagged.
    d_wr = 1'b1; d_addr = 16'h0005; d_val = 16'hBEEF;
    @(posedge clk); #1;
    rst = 1'b1; d_wr = 1'b0; d_val = 16'h0000;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (d_rdy !== 1'b0 || d_bus !== 16'h0000) begin
        failures++;
        $display("FAIL reset_abort got ready=%b bus=%h want 0 0000", d_rdy, d_bus);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    d_req(1'b1, 1'b0, 16'h0005, 16'h0000, 16'hCAFE);
    finish_reqs();
  endtask

  task automatic test_latency();
    d_req(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000);
    finish_reqs();
    d_req(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234);
    finish_reqs();
  endtask

  task automatic test_concurrent();
    i_req(1'b0, 1'b1, 16'h0020, 16'hAAAA, 16'h0000);
    d_req(1'b0, 1'b1, 16'h0021, 16'h5555, 16'h0000);
    finish_reqs();
    i_req(1'b1, 1'b0, 16'h0020, 16'h0000, 16'hAAAA);
    d_req(1'b1, 1'b0, 16'h0021, 16'h0000, 16'h5555);
    finish_reqs();
  endtask

  task automatic test_collisions();
    i_req(1'b0, 1'b1, 16'h0030, 16'h1111, 16'h0000);
    d_req(1'b0, 1'b1, 16'h0030, 16'h2222, 16'h0000);
    finish_reqs();
    i_req(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h2222);
    d_req(1'b0, 1'b1, 16'h0031, 16'h0A0A, 16'h0000);
    finish_reqs();
    // Read and write of one index commit together: the read sees the old word.
    i_req(1'b0, 1'b1, 16'h0031, 16'h0B0B, 16'h0000);
    d_req(1'b1, 1'b0, 16'h0031, 16'h0000, 16'h0A0A);
    finish_reqs();
    d_req(1'b1, 1'b1, 16'h0031, 16'h0C0C, 16'h0000);
    finish_reqs();
    i_req(1'b1, 1'b0, 16'h0131, 16'h0000, 16'h0C0C);
    finish_reqs();
  endtask

  task automatic test_alias_back_to_back();
    exp_t e;
    int   n, seen;
    d_req(1'b0, 1'b1, 16'h0140, 16'h7777, 16'h0000);
    finish_reqs();
    d_req(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h7777);
    e.is_read = 1'b1; e.data = 16'h7777; e.rdy_cyc = cyc + 1 + LAT + 2 + LAT;
    dq.push_back(e);
    n = 0; seen = 0;
    while (seen < 2 && n < 20) begin
      @(negedge clk);
      if (d_rdy) seen++;
      @(posedge clk); #1;
      if (seen == 2) d_rd = 1'b0;
      n++;
    end
    checks++;
    if (seen != 2) begin
      failures++;
      $display("FAIL back_to_back_pulses got %0d want 2", seen);
      d_rd = 1'b0; dq.delete();
    end
  endtask

  task automatic test_latency1();
    int   k;
    logic exp_rdy;
    u_i_wr = 1'b1; u_i_addr = 16'h0003; u_i_val = 16'h5A5A;
    @(negedge clk);
    checks++;
    if (u_i_rdy !== 1'b0) begin
      failures++;
      $display("FAIL lat1_write_early got %b want 0", u_i_rdy);
    end
    @(negedge clk);
    checks++;
    if (u_i_rdy !== 1'b1) begin
      failures++;
      $display("FAIL lat1_write_ready got %b want 1", u_i_rdy);
    end
    @(posedge clk); #1;
    u_i_wr = 1'b0; u_i_val = 16'h0000;
    @(posedge clk); #1;
    u_i_rd = 1'b1;
    k = cyc;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_rdy = (cyc >= k + 1) && (((cyc - (k + 1)) % 2) == 0);
      checks++;
      if (u_i_rdy !== exp_rdy) begin
        failures++;
        $display("FAIL lat1_ready_cadence cyc=%0d got %b want %b", cyc, u_i_rdy, exp_rdy);
      end
      checks++;
      if (u_i_bus !== (exp_rdy ? 16'h5A5A : 16'h0000)) begin
        failures++;
        $display("FAIL lat1_bus cyc=%0d got %h want %h", cyc, u_i_bus, exp_rdy ? 16'h5A5A : 16'h0000);
      end
    end
    @(posedge clk); #1;
    u_i_rd = 1'b0;
  endtask

  initial begin
    i_rd = 1'b0; i_wr = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0000; d_addr = 16'h0000; i_val = 16'h0000; d_val = 16'h0000;
    u_i_rd = 1'b0; u_i_wr = 1'b0; u_d_rd = 1'b0; u_d_wr = 1'b0;
    u_i_addr = 16'h0000; u_d_addr = 16'h0000; u_i_val = 16'h0000; u_d_val = 16'h0000;
    #1 rst = 1'b1;
    test_reset();
    test_latency();
    test_concurrent();
    test_collisions();
    test_alias_back_to_back();
    test_latency1();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (iq.size() != 0 || dq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got i=%0d d=%0d pending want 0 0", iq.size(), dq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
